pia_port_ctrl: RTL and testbench

PIA_PORT_CTRL -- requirements
Module: pia_port_ctrl

---
 rtl/pia_port_ctrl.sv | 178 +++++++++++++++++
 tb/tb_pia_port_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pia_port_ctrl.sv
// pia_port_ctrl: control register, CA1/CA2 edge flags and CA2 output
// sequencer of one side of a 6821-style peripheral interface adapter.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   cs1, cs2, cs3         chip selects (selected when cs1 & cs2 & ~cs3)
//   rw, rs, din           CPU read/write, register select, write data
//   dout                  control register read data
//   ca1                   peripheral handshake input (asynchronous)
//   ca2_in/out/oe         split CA2 line
//   ddr_sel               1 = data region maps to the DDR
//   data_strobe           one-cycle pulse on a peripheral data read
//   irq_n                 active-low interrupt request
module pia_port_ctrl #(
    parameter int PULSE_LEN = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cs1,
    input  logic       cs2,
    input  logic       cs3,
    input  logic       rw,
    input  logic       rs,
    input  logic [7:0] din,
    output logic [7:0] dout,
    input  logic       ca1,
    input  logic       ca2_in,
    output logic       ca2_out,
    output logic       ca2_oe,
    output logic       ddr_sel,
    output logic       data_strobe,
    output logic       irq_n
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HS_WAIT = 2'd1,
        PULSE   = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nx;
    logic [3:0] cnt;
    logic [3:0] cnt_nx;
    logic [7:0] cr;

    logic sel;
    logic wr;
    logic prd;
    logic ca1_s1;
    logic ca1_s2;
    logic ca1_prev;
    logic ca2_s1;
    logic ca2_s2;
    logic ca2_prev;
    logic ca1_edge;
    logic ca2_edge;
    logic manual;
    logic hs_mode;
    logic pl_mode;
    logic mode_chg;

    assign sel = cs1 & cs2 & ~cs3;
    assign wr  = sel & ~rw & rs;
    assign prd = sel & rw & ~rs & cr[2];

    // Edge is judged on the synchronized value against one cycle older.
    assign ca1_edge = cr[1] ? (ca1_s2 & ~ca1_prev) : (~ca1_s2 & ca1_prev);
    assign ca2_edge = ~cr[5] &
                      (cr[4] ? (ca2_s2 & ~ca2_prev) : (~ca2_s2 & ca2_prev));

    assign manual   = (cr[5:4] == 2'b11);
    assign hs_mode  = (cr[5:3] == 3'b100);
    assign pl_mode  = (cr[5:3] == 3'b101);
    assign mode_chg = wr & (din[5:3] != cr[5:3]);

    assign dout        = (sel & rw & rs) ? cr : 8'h00;
    assign ddr_sel     = ~cr[2];
    assign data_strobe = prd;
    assign ca2_oe      = cr[5];
    assign irq_n       = ~((cr[7] & cr[0]) | (cr[6] & cr[3] & ~cr[5]));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ca1_s1   <= 1'b0;
            ca1_s2   <= 1'b0;
            ca1_prev <= 1'b0;
            ca2_s1   <= 1'b0;
            ca2_s2   <= 1'b0;
            ca2_prev <= 1'b0;
        end else begin
            ca1_s1   <= ca1;
            ca1_s2   <= ca1_s1;
            ca1_prev <= ca1_s2;
            ca2_s1   <= ca2_in;
            ca2_s2   <= ca2_s1;
            ca2_prev <= ca2_s2;
        end
    end

    // Flag set beats a clearing data read; entering CA2 output mode
    // clears IRQ2 outright so it can never appear set in that mode.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cr <= 8'h00;
        end else begin
            if (wr) begin
                cr[5:0] <= din[5:0];
            end
            if (ca1_edge) begin
                cr[7] <= 1'b1;
            end else if (prd) begin
                cr[7] <= 1'b0;
            end
            if (wr && din[5]) begin
                cr[6] <= 1'b0;
            end else if (ca2_edge) begin
                cr[6] <= 1'b1;
            end else if (prd) begin
                cr[6] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (manual || mode_chg) begin
            state_nx = IDLE;
            cnt_nx   = 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (prd && hs_mode) begin
                        state_nx = HS_WAIT;
                    end else if (prd && pl_mode) begin
                        state_nx = PULSE;
                        cnt_nx   = 4'(PULSE_LEN);
                    end
                end
                HS_WAIT: begin
                    if (ca1_edge) begin
                        state_nx = IDLE;
                    end
                end
                PULSE: begin
                    cnt_nx = cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state_nx = IDLE;
                    end
                end
                default: begin
                    state_nx = IDLE;
                    cnt_nx   = 4'd0;
                end
            endcase
        end
    end

    always_comb begin
        ca2_out = 1'b1;
        if (manual) begin
            ca2_out = cr[3];
        end else if (state != IDLE) begin
            ca2_out = 1'b0;
        end
    end

endmodule

// File: tb/tb_pia_port_ctrl.sv
// tb_pia_port_ctrl: directed and random stimulus against a history-based
// reference model; expected outputs are queued and checked by a monitor.
module tb_pia_port_ctrl;

    localparam int PL = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       cs1, cs2, cs3, rw, rs;
    logic [7:0] din;
    logic [7:0] dout;
    logic       ca1, ca2_in;
    logic       ca2_out, ca2_oe, ddr_sel, data_strobe, irq_n;

    always #5 clk = ~clk;

    pia_port_ctrl #(.PULSE_LEN(PL)) dut (
        .clk(clk), .reset(reset),
        .cs1(cs1), .cs2(cs2), .cs3(cs3),
        .rw(rw), .rs(rs), .din(din), .dout(dout),
        .ca1(ca1), .ca2_in(ca2_in),
        .ca2_out(ca2_out), .ca2_oe(ca2_oe),
        .ddr_sel(ddr_sel), .data_strobe(data_strobe),
        .irq_n(irq_n)
    );

    typedef struct {
        logic [7:0] dout;
        logic       ddr_sel;
        logic       data_strobe;
        logic       irq_n;
        logic       ca2_out;
        logic       ca2_oe;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // reference model state
    logic [7:0] mcr;
    bit         q1[$];
    bit         q2[$];
    bit         hs;
    int         pl;
    logic       c1, c2;

    task automatic cmp(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        mcr = 8'h00;
        q1  = '{0, 0, 0};
        q2  = '{0, 0, 0};
        hs  = 0;
        pl  = 0;
    endtask

    task automatic m_expect(output exp_t e);
        bit s;
        s = cs1 & cs2 & ~cs3;
        e.dout        = (s && rw && rs) ? mcr : 8'h00;
        e.ddr_sel     = ~mcr[2];
        e.data_strobe = s && rw && !rs && mcr[2];
        e.irq_n       = !((mcr[7] && mcr[0]) ||
                          (mcr[6] && mcr[3] && !mcr[5]));
        e.ca2_oe      = mcr[5];
        if (mcr[5:4] == 2'b11) e.ca2_out = mcr[3];
        else e.ca2_out = !(hs || pl > 0);
    endtask

    // q[0]/q[1] are the samples taken three and two edges ago.
    task automatic m_step();
        bit s, w, p, e1, e2;
        logic [7:0] n;
        s  = cs1 & cs2 & ~cs3;
        w  = s && !rw && rs;
        p  = s && rw && !rs && mcr[2];
        e1 = mcr[1] ? (q1[1] && !q1[0]) : (!q1[1] && q1[0]);
        e2 = !mcr[5] &&
             (mcr[4] ? (q2[1] && !q2[0]) : (!q2[1] && q2[0]));
        if (mcr[5:4] == 2'b11 || (w && din[5:3] != mcr[5:3])) begin
            hs = 0;
            pl = 0;
        end else if (hs) begin
            if (e1) hs = 0;
        end else if (pl > 0) begin
            pl = pl - 1;
        end else if (p && mcr[5:3] == 3'b100) begin
            hs = 1;
        end else if (p && mcr[5:3] == 3'b101) begin
            pl = PL;
        end
        n = mcr;
        if (w) n[5:0] = din[5:0];
        if (e1) n[7] = 1'b1;
        else if (p) n[7] = 1'b0;
        if (w && din[5]) n[6] = 1'b0;
        else if (e2) n[6] = 1'b1;
        else if (p) n[6] = 1'b0;
        mcr = n;
        q1.push_back(ca1);
        q1.delete(0);
        q2.push_back(ca2_in);
        q2.delete(0);
    endtask

    task automatic cyc(input logic [2:0] cs, input logic rw_i,
                       input logic rs_i, input logic [7:0] d,
                       input logic a1, input logic a2, input logic r);
        exp_t e;
        @(negedge clk);
        {cs1, cs2, cs3} = cs;
        rw = rw_i;
        rs = rs_i;
        din = d;
        ca1 = a1;
        ca2_in = a2;
        reset = r;
        if (r) m_reset();
        m_expect(e);
        sb.push_back(e);
        if (!r) m_step();
        #2;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(3'b000, 1'b0, 1'b0, 8'h00, c1, c2, 1'b0);
    endtask

    task automatic wr_cr(input logic [7:0] d);
        cyc(3'b110, 1'b0, 1'b1, d, c1, c2, 1'b0);
    endtask

    task automatic rd_cr();
        cyc(3'b110, 1'b1, 1'b1, 8'h00, c1, c2, 1'b0);
    endtask

    task automatic prd();
        cyc(3'b110, 1'b1, 1'b0, 8'h00, c1, c2, 1'b0);
    endtask

    // monitor: compare every presented output set with the queued one
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                cmp("sb_dout", dout, e.dout);
                cmp("sb_ddr_sel", ddr_sel, e.ddr_sel);
                cmp("sb_strobe", data_strobe, e.data_strobe);
                cmp("sb_irq_n", irq_n, e.irq_n);
                cmp("sb_ca2_out", ca2_out, e.ca2_out);
                cmp("sb_ca2_oe", ca2_oe, e.ca2_oe);
            end
        end
    end

    initial begin
        int low;
        reset = 1'b1;
        {cs1, cs2, cs3} = 3'b000;
        rw = 1'b0;
        rs = 1'b0;
        din = 8'h00;
        ca1 = 1'b0;
        ca2_in = 1'b0;
        c1 = 1'b0;
        c2 = 1'b0;
        m_reset();

        cyc(3'b000, 1'b0, 1'b0, 8'h00, c1, c2, 1'b1);
        cmp("rst_irq_n", irq_n, 1'b1);
        cmp("rst_ddr_sel", ddr_sel, 1'b1);
        cmp("rst_ca2_out", ca2_out, 1'b1);
        cyc(3'b000, 1'b0, 1'b0, 8'h00, c1, c2, 1'b1);

        // control register write/readback
        wr_cr(8'hFF);
        rd_cr();
        cmp("cr_rd_3f", dout, 8'h3F);
        cmp("ddr_sel_0", ddr_sel, 1'b0);

        // CA1 falling edge sets IRQ1 two edges after first sampling
        wr_cr(8'h05);
        c1 = 1'b1;
        idle(4);
        c1 = 1'b0;
        idle(3);
        cmp("irq1_early", irq_n, 1'b1);
        idle(1);
        cmp("irq1_set", irq_n, 1'b0);
        prd();
        cmp("strobe", data_strobe, 1'b1);
        idle(1);
        cmp("irq1_clr", irq_n, 1'b1);

        // handshake mode
        wr_cr(8'h24);
        c1 = 1'b1;
        idle(4);
        prd();
        idle(1);
        cmp("hs_low", ca2_out, 1'b0);
        c1 = 1'b0;
        idle(3);
        cmp("hs_hold", ca2_out, 1'b0);
        idle(1);
        cmp("hs_release", ca2_out, 1'b1);
        rd_cr();
        cmp("hs_cr", dout, 8'hA4);

        // pulse mode with a second read mid-pulse
        wr_cr(8'h2C);
        prd();
        low = 0;
        for (int i = 0; i < 8; i++) begin
            if (i == 1) prd();
            else idle(1);
            if (ca2_out == 1'b0) low++;
        end
        cmp("pulse_len", low, PL);

        // CA1 edge and data read on the same edge
        wr_cr(8'h05);
        prd();
        idle(1);
        c1 = 1'b1;
        idle(4);
        c1 = 1'b0;
        idle(2);
        prd();
        idle(1);
        rd_cr();
        cmp("set_wins", dout, 8'h85);

        // reset during a pulse
        wr_cr(8'h2C);
        prd();
        idle(1);
        cmp("pulse_on", ca2_out, 1'b0);
        cyc(3'b110, 1'b1, 1'b1, 8'h00, c1, c2, 1'b1);
        cmp("rst_pulse_ca2", ca2_out, 1'b1);
        cmp("rst_pulse_irq", irq_n, 1'b1);
        cmp("rst_pulse_cr", dout, 8'h00);
        cmp("rst_pulse_oe", ca2_oe, 1'b0);
        idle(2);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            logic [2:0] cs;
            logic       r;
            if ($urandom_range(3) == 0) c1 = ~c1;
            if ($urandom_range(3) == 0) c2 = ~c2;
            cs = ($urandom_range(3) != 0) ? 3'b110 : 3'($urandom);
            r = ($urandom_range(299) == 0);
            cyc(cs, 1'($urandom), 1'($urandom), 8'($urandom), c1, c2, r);
        end

        idle(2);
        cmp("sb_drain", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
